display_scan_mux: RTL



---
 rtl/display_scan_mux.sv | 94 +++++++++
 1 files changed

// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexes a double-buffered packed BCD value one digit per slot.
// Define DISPLAY_SCAN_LZB_EN to enable leading-zero blanking of the digit enables.
module display_scan_mux #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*DIGITS-1:0]       bcd_in,
  input  logic                      load,
  output logic [3:0]                bcd_out,
  output logic [DIGITS-1:0]         an,
  output logic [$clog2(DIGITS)-1:0] digit_idx,
  output logic                      frame_tick,
  output logic                      busy_pending
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] disp;
  logic [4*DIGITS-1:0] pend;
  logic                pend_v;
  logic                slot_end;
  logic                suppress;

  assign slot_end   = (cnt == LAST_CNT);
  assign frame_tick = slot_end && (idx == LAST_IDX);

  // Producer updates land in pend; disp only changes on the frame_tick cycle so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      disp   <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (frame_tick) begin
        if (load)
          disp <= bcd_in;
        else if (pend_v)
          disp <= pend;
        pend_v <= 1'b0;
      end else if (load) begin
        pend   <= bcd_in;
        pend_v <= 1'b1;
      end
    end
  end

`ifdef DISPLAY_SCAN_LZB_EN
  logic [DIGITS-1:0] lead_zero;

  // A digit is a leading zero when it and every more significant nibble are zero; digit 0 never is.
  always_comb begin : lzb_scan
    logic zero_run;
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run     = zero_run && (disp[4*k +: 4] == 4'd0);
      lead_zero[k] = zero_run;
    end
  end

  assign suppress = lead_zero[idx];
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    an = '0;
    if ((cnt >= BLANK_END) && !suppress)
      an[idx] = 1'b1;
  end

  assign bcd_out      = disp[{idx, 2'b00} +: 4];
  assign digit_idx    = idx;
  assign busy_pending = pend_v;

endmodule
